// File: rtl/rom_port_arbiter.sv
// Arbitrates a CPU read port and a loader write port onto two single-port ROMs
// (system BIOS and XTIDE option ROM). The loader has priority; the CPU side
// decodes the physical address into a BIOS window, an XTIDE window or unmapped.
// All port-facing outputs are registered.
module rom_port_arbiter #(
    parameter logic [19:0] XTIDE_BASE = 20'hC8000,
    parameter bit          XTIDE_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic [19:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,

    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic        ld_target,
    input  logic [16:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,

    output logic        bios_ena,
    output logic        bios_wea,
    output logic [16:0] bios_addr,
    output logic [7:0]  bios_din,
    input  logic [7:0]  bios_dout,

    output logic        xt_ena,
    output logic        xt_wea,
    output logic [13:0] xt_addr,
    output logic [7:0]  xt_din,
    input  logic [7:0]  xt_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StRdDone,
        StWrIssue,
        StWrDone
    } state_t;

    state_t state;
    logic   rd_xt;      // read in flight targets the XTIDE port
    logic   bios_hit;
    logic   xt_hit;

    // Address window decode; BIOS takes precedence should the windows overlap.
    always_comb begin
        bios_hit = (cpu_addr[19:17] == 3'b111);
        xt_hit   = XTIDE_EN && (cpu_addr[19:14] == XTIDE_BASE[19:14]) && !bios_hit;
    end

    // Control FSM with registered port, ack and data outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            rd_xt     <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_data  <= 8'h00;
            ld_ack    <= 1'b0;
            bios_ena  <= 1'b0;
            bios_wea  <= 1'b0;
            bios_addr <= 17'h0;
            bios_din  <= 8'h00;
            xt_ena    <= 1'b0;
            xt_wea    <= 1'b0;
            xt_addr   <= 14'h0;
            xt_din    <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (ld_wr) begin
                        if (ld_target) begin
                            xt_ena  <= 1'b1;
                            xt_wea  <= 1'b1;
                            xt_addr <= ld_addr[13:0];
                            xt_din  <= ld_data;
                        end else begin
                            bios_ena  <= 1'b1;
                            bios_wea  <= 1'b1;
                            bios_addr <= ld_addr;
                            bios_din  <= ld_data;
                        end
                        state <= StWrIssue;
                    end else if (cpu_req && !ld_active) begin
                        if (bios_hit) begin
                            bios_ena  <= 1'b1;
                            bios_wea  <= 1'b0;
                            bios_addr <= cpu_addr[16:0];
                            rd_xt     <= 1'b0;
                            state     <= StRdIssue;
                        end else if (xt_hit) begin
                            xt_ena  <= 1'b1;
                            xt_wea  <= 1'b0;
                            xt_addr <= cpu_addr[13:0];
                            rd_xt   <= 1'b1;
                            state   <= StRdIssue;
                        end else begin
                            // Unmapped: open-bus value, no port touched
                            cpu_data <= 8'hFF;
                            cpu_ack  <= 1'b1;
                            state    <= StRdDone;
                        end
                    end
                end
                StRdIssue: begin
                    bios_ena <= 1'b0;
                    xt_ena   <= 1'b0;
                    state    <= StRdWait;
                end
                StRdWait: begin
                    cpu_data <= rd_xt ? xt_dout : bios_dout;
                    cpu_ack  <= 1'b1;
                    state    <= StRdDone;
                end
                StRdDone: begin
                    state <= StIdle;
                end
                StWrIssue: begin
                    bios_ena <= 1'b0;
                    bios_wea <= 1'b0;
                    xt_ena   <= 1'b0;
                    xt_wea   <= 1'b0;
                    ld_ack   <= 1'b1;
                    state    <= StWrDone;
                end
                StWrDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
